// File: rtl/img_stream_tx.sv
// Image stream transmitter: buffers one frame, then streams it byte-by-byte with pause gaps and looping.
// Byte 0 is valid two edges after start is sampled; pause inserts one invalid cycle per sampled edge.
module img_stream_tx #(
  parameter int Img_Dim = 4,
  parameter int Img_Ch  = 3,
  parameter int Data_W  = 8,
  localparam int N      = Img_Dim * Img_Dim * Img_Ch,
  localparam int AW     = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [Data_W-1:0] wr_data,
  input  logic              start,
  input  logic              pause,
  input  logic              loop,
  output logic [Data_W-1:0] out_img_stream,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output logic [7:0]        frame_cnt
);

  localparam logic [AW-1:0] LAST  = AW'(N - 1);
  localparam logic [AW:0]   N_EXT = (AW + 1)'(N);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t              state_q;
  logic [AW-1:0]       ptr_q;
  logic [Data_W-1:0]   dat_q;
  logic                vld_q;
  logic                busy_q;
  logic                done_q;
  logic [7:0]          frame_cnt_q;
  logic [Data_W-1:0]   mem [N];

  // Buffer has no reset so a loaded image survives a reset pulse.
  always_ff @(posedge clk) begin
    if (wr_en && !busy_q && ({1'b0, wr_addr} < N_EXT)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      dat_q       <= '0;
      vld_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          vld_q <= 1'b0;
          ptr_q <= '0;
          if (start) begin
            state_q <= STREAM;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        STREAM: begin
          busy_q <= 1'b1;
          if (pause) begin
            vld_q <= 1'b0;
          end else begin
            dat_q <= mem[ptr_q];
            vld_q <= 1'b1;
            if (ptr_q == LAST) begin
              frame_cnt_q <= frame_cnt_q + 8'd1;
              ptr_q       <= '0;
              if (!loop) state_q <= DONE;
            end else begin
              ptr_q <= ptr_q + AW'(1);
            end
          end
        end
        DONE: begin
          // busy stays up through the done pulse and drops on the following edge.
          vld_q   <= 1'b0;
          done_q  <= 1'b1;
          busy_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          vld_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_img_stream = dat_q;
  assign out_valid      = vld_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign frame_cnt      = frame_cnt_q;

endmodule

// File: tb/tb_img_stream_tx.sv
// Directed bench for img_stream_tx: frame, pause, loop, ignored inputs, async reset, counter wrap.
module tb_img_stream_tx;

  localparam int N = 48;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic       start;
  logic       pause;
  logic       loop;
  logic [7:0] out_img_stream;
  logic       out_valid;
  logic       busy;
  logic       done;
  logic [7:0] frame_cnt;

  int vecs = 0;
  int errs = 0;

  int         cyc = 0;
  logic [7:0] beats[$];
  int         vcyc[$];
  int         dcyc[$];
  logic       dbusy[$];

  img_stream_tx dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .pause(pause), .loop(loop), .out_img_stream(out_img_stream),
    .out_valid(out_valid), .busy(busy), .done(done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (out_valid) begin
      beats.push_back(out_img_stream);
      vcyc.push_back(cyc);
    end
    if (done) begin
      dcyc.push_back(cyc);
      dbusy.push_back(busy);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    beats.delete();
    vcyc.delete();
    dcyc.delete();
    dbusy.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy) break;
      step(1);
    end
    chk({tag, "_idle_tmo"}, busy, 1'b0);
    step(2);
  endtask

  task automatic wait_beat(input string tag, input logic [7:0] val);
    int k;
    for (k = 0; k < 200; k++) begin
      step(1);
      if (out_valid && out_img_stream == val) break;
    end
    chk({tag, "_beat_tmo"}, k < 200, 1'b1);
  endtask

  task automatic check_frames(input string tag, input int nb);
    chk({tag, "_nbeats"}, beats.size(), nb);
    for (int i = 0; i < nb && i < beats.size(); i++)
      chk({tag, "_val"}, beats[i], i % N);
    chk({tag, "_ndone"}, dcyc.size(), 1);
    if (dcyc.size() > 0 && vcyc.size() > 0) begin
      chk({tag, "_done_pos"}, dcyc[0] - vcyc[vcyc.size()-1], 1);
      chk({tag, "_done_busy"}, dbusy[0], 1'b1);
    end
  endtask

  initial begin
    int k;
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; pause = 1'b0; loop = 1'b0;
    step(2);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_data", out_img_stream, 8'h00);
    chk("rst_fcnt", frame_cnt, 8'h00);
    rst = 1'b1;
    step(1);
    for (int i = 0; i < N; i++) begin
      wr_en = 1'b1; wr_addr = 6'(i); wr_data = 8'(i);
      step(1);
    end
    wr_en = 1'b0;
    step(1);

    // basic frame
    clear_mon();
    pulse_start();
    chk("lat_busy", busy, 1'b1);
    chk("lat_valid0", out_valid, 1'b0);
    step(1);
    chk("lat_valid1", out_valid, 1'b1);
    chk("lat_byte0", out_img_stream, 8'h00);
    wait_idle("basic", 100);
    check_frames("basic", N);
    if (vcyc.size() == N) chk("basic_contig", vcyc[N-1] - vcyc[0], N - 1);
    if (dcyc.size() > 0 && vcyc.size() > 0) chk("basic_done_ofs", dcyc[0] - vcyc[0], N);
    chk("basic_fcnt", frame_cnt, 8'd1);
    chk("basic_busy", busy, 1'b0);

    // pause gap of 5 after beat 22
    clear_mon();
    pulse_start();
    wait_beat("pause", 8'd22);
    pause = 1'b1;
    step(5);
    pause = 1'b0;
    wait_idle("pause", 100);
    check_frames("pause", N);
    if (vcyc.size() == N) begin
      chk("pause_pre", vcyc[22] - vcyc[0], 22);
      chk("pause_gap", vcyc[23] - vcyc[22], 6);
      chk("pause_post", vcyc[N-1] - vcyc[23], 24);
    end
    if (dcyc.size() > 0 && vcyc.size() > 0) chk("pause_done_ofs", dcyc[0] - vcyc[0], N + 5);
    chk("pause_fcnt", frame_cnt, 8'd2);

    // loop three frames (reset first; buffer must survive)
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    step(1);
    clear_mon();
    loop = 1'b1;
    pulse_start();
    for (k = 0; k < 400; k++) begin
      if (frame_cnt == 8'd2) break;
      step(1);
    end
    chk("loop_tmo", k < 400, 1'b1);
    loop = 1'b0;
    wait_idle("loop", 200);
    check_frames("loop", 3 * N);
    if (vcyc.size() == 3 * N) chk("loop_contig", vcyc[3*N-1] - vcyc[0], 3 * N - 1);
    chk("loop_fcnt", frame_cnt, 8'd3);

    // ignored inputs: out-of-range write idle, in-range write and start while busy
    wr_en = 1'b1; wr_addr = 6'd50; wr_data = 8'hAA;
    step(1);
    wr_en = 1'b0;
    clear_mon();
    pulse_start();
    wait_beat("ign", 8'd5);
    wr_en = 1'b1; wr_addr = 6'd10; wr_data = 8'hFF; start = 1'b1;
    step(1);
    wr_en = 1'b0; start = 1'b0;
    wait_idle("ign", 100);
    check_frames("ign", N);
    chk("ign_fcnt", frame_cnt, 8'd4);
    clear_mon();
    pulse_start();
    wait_idle("ign2", 100);
    check_frames("ign2", N);

    // asynchronous reset mid-frame
    clear_mon();
    pulse_start();
    wait_beat("arst", 8'd20);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_data", out_img_stream, 8'h00);
    chk("arst_fcnt", frame_cnt, 8'h00);
    chk("arst_done", done, 1'b0);
    step(2);
    rst = 1'b1;
    step(1);
    clear_mon();
    pulse_start();
    wait_idle("arst", 100);
    check_frames("arst", N);
    chk("arst_fcnt2", frame_cnt, 8'd1);

    // frame counter wrap
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    step(1);
    loop = 1'b1;
    pulse_start();
    for (k = 0; k < 256 * N + 200; k++) begin
      if (frame_cnt == 8'd255) break;
      step(1);
    end
    chk("wrap_tmo255", frame_cnt, 8'd255);
    for (k = 0; k < 200; k++) begin
      if (frame_cnt != 8'd255) break;
      step(1);
    end
    chk("wrap_cnt0", frame_cnt, 8'd0);
    chk("wrap_lastv", out_valid, 1'b1);
    chk("wrap_lastb", out_img_stream, 8'd47);
    loop = 1'b0;
    wait_idle("wrap", 200);
    chk("wrap_cnt1", frame_cnt, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/img_stream_tx.md
# img_stream_tx

Image stream transmitter feeding the convolution engine's pixel input. It holds one full image (Img_Dim × Img_Dim × Img_Ch bytes) in a local buffer loaded through a simple write port. On `start` it streams the bytes in ascending address order as `out_img_stream` with `out_valid`, which connects directly to the Conv `in_img_stream`/`in_valid` pair. It supports pause gaps, back-to-back looping frames and a frame-done pulse. It replaces hand-driven bench stimulus on the Conv input path.

## Interface
- `Img_Dim`, 4: image width and height in pixels.
- `Img_Ch`, 3: channels per pixel.
- `Data_W`, 8: stream byte width.
- `N` (localparam) = Img_Dim*Img_Dim*Img_Ch: bytes per frame.
- `AW` (localparam) = $clog2(N): address width.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  buffer write strobe.
- `wr_addr`  in  AW  buffer write address; byte order is ((row*Img_Dim+col)*Img_Ch+ch).
- `wr_data`  in  Data_W  buffer write data.
- `start`  in  1  begin frame transmission; level-sampled.
- `pause`  in  1  insert an invalid cycle instead of the next byte.
- `loop`  in  1  at frame end, restart at byte 0 with no gap.
- `out_img_stream`  out  Data_W  streamed byte, registered.
- `out_valid`  out  1  `out_img_stream` holds a valid byte this cycle, registered.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse after the last byte of a non-looped frame.
- `frame_cnt`  out  8  completed-frame counter; wraps from 255 to 0.

## Operation
- **Buffer.** N×Data_W register/RAM array.
  - Not cleared by reset; contents survive reset.
  - A write occurs when `wr_en` is high, `busy` is low and `wr_addr` < N.
  - Writes are ignored when `busy` is high or `wr_addr` ≥ N. Dropped writes are silent.
- **FSM states:** IDLE, STREAM, DONE.
- **IDLE.**
  - `out_valid`=0 and `ptr`=0.
  - `start`=1 at an edge → STREAM.
  - `start` is ignored in every other state.
- **STREAM**, at each edge:
  - If `pause`=1: `out_valid`←0 and `ptr` holds. `out_img_stream` keeps its last value.
  - Otherwise: `out_img_stream`←mem[`ptr`], `out_valid`←1.
    - If `ptr`<N-1: `ptr`←`ptr`+1.
    - If `ptr`=N-1: `frame_cnt`←`frame_cnt`+1, then:
      - `loop`=1 → `ptr`←0 and stay in STREAM, so byte 0 of the next frame follows the last byte with no gap.
      - `loop`=0 → go to DONE.
- **DONE.** For one cycle: `out_valid`=0 and `done`=1. Then → IDLE.
- `pause` and `loop` matter only in STREAM. `pause` has priority over the last-byte check: a paused cycle never ends a frame.
- `loop` is sampled only on the cycle that emits byte N-1.
- **Reset (`rst`=0)**, asynchronous and legal at any time including mid-frame:
  - State→IDLE, `ptr`=0.
  - Outputs: `out_valid`=0, `out_img_stream`=0, `busy`=0, `done`=0, `frame_cnt`=0.
  - A frame interrupted by reset is abandoned and not counted.

## Timing
- **Start latency:** `start` sampled at edge E → first valid byte (byte 0) visible in the cycle after edge E+1.
- `busy` rises in the cycle after edge E.
- **Unpaused frame:** N consecutive `out_valid` cycles. In the cycle after the last byte, `done`=1 and `busy`=1. `busy`=0 one cycle later.
- **Pause:** `pause` high for k edges yields exactly k invalid cycles, inserted one cycle after `pause` is sampled. Byte order and values are unchanged.
- **frame_cnt:** updates in the same cycle the last byte is presented.
- **Back-to-back frames:** `start` held high continuously with `loop`=0 gives a 2-cycle gap between frames:
  - the DONE cycle;
  - the IDLE cycle that samples `start`.

## Test plan
- **Basic frame.** Reset; write mem[i]=i for i=0..47 (defaults); pulse `start`.
  - Exactly 48 contiguous valid beats with values 0..47.
  - `done` pulses once, the cycle after beat 47.
  - `frame_cnt`=1 and `busy`=0 afterward.
- **Pause gap.** As the basic frame, but hold `pause` high for 5 edges after beat 22.
  - Bytes 0..22, then 5 invalid cycles, then 23..47.
  - No byte is duplicated or lost.
  - `done` arrives 5 cycles later than in the basic frame.
- **Loop.** `loop`=1 throughout, then drop `loop` during the third frame.
  - Three frames run back to back with no invalid cycle between beat 47 and the next beat 0.
  - `frame_cnt` reaches 3 and a single `done` follows the third frame.
- **Ignored inputs while busy.** During STREAM, issue `wr_en` writing 0xFF to mem[10], and issue a second `start` pulse.
  - The current frame is unchanged and no restart occurs.
  - After `done`, re-`start` shows mem[10]=10.
  - Also write to `wr_addr`=50 while idle: no effect on the frame.
- **Reset mid-frame.** Assert `rst`=0 asynchronously (off-edge) after beat 20.
  - `out_valid`, `busy`, `out_img_stream` and `frame_cnt` go to 0 immediately.
  - After release and `start`, the buffer is intact and bytes 0..47 stream again.
- **Wrap.** Stream 256 looped frames.
  - `frame_cnt` wraps 255→0 on the 256th completion.
